// File: rtl/image_write_pkg.sv
// Shared config map and FSM encoding for the image buffer writer.
// Register addresses sit next to the image_read block's map so both can share one config bus.
package image_write_pkg;

  localparam int unsigned CFG_IR_IMG_W  = 0;
  localparam int unsigned CFG_IR_IMG_DH = 1;
  localparam int unsigned CFG_IR_START  = 2;
  localparam int unsigned CFG_IW_IMG_W  = 3;
  localparam int unsigned CFG_IW_IMG_DH = 4;
  localparam int unsigned CFG_IW_START  = 5;

  localparam int unsigned DIM_W = 16;

  // Bit positions within the one-hot state vector
  localparam int unsigned RESET  = 0;
  localparam int unsigned ACTIVE = 1;
  localparam int unsigned DONE   = 2;

  typedef enum logic [2:0] {
    StReset  = 3'b001,
    StActive = 3'b010,
    StDone   = 3'b100
  } state_e;

endpackage

// File: rtl/image_write_count.sv
// Nested width/height/depth counter; width is innermost.
// Limits are inclusive maxima (size-1), so each *_last_o is a simple equality.
module image_write_count
  import image_write_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DIM_W-1:0] img_w_i,
  input  logic [DIM_W-1:0] img_h_i,
  input  logic [DIM_W-1:0] img_d_i,
  output logic             w_last_o,
  output logic             h_last_o,
  output logic             d_last_o
);

  logic [DIM_W-1:0] w_q, h_q, d_q;

  assign w_last_o = (w_q == img_w_i);
  assign h_last_o = (h_q == img_h_i);
  assign d_last_o = (d_q == img_d_i);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      w_q <= '0;
      h_q <= '0;
      d_q <= '0;
    end else if (en_i) begin
      if (!w_last_o) begin
        w_q <= w_q + DIM_W'(1);
      end else begin
        w_q <= '0;
        if (!h_last_o) begin
          h_q <= h_q + DIM_W'(1);
        end else begin
          h_q <= '0;
          d_q <= d_last_o ? '0 : d_q + DIM_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/image_write.sv
// Stream-to-buffer writer: stores incoming words at consecutive addresses from a base and
// flags any disagreement between the upstream last marker and the configured image size.
module image_write
  import image_write_pkg::*;
#(
  parameter int unsigned CFG_DWIDTH = 32,
  parameter int unsigned CFG_AWIDTH = 5,
  parameter int unsigned GROUP_NB   = 4,
  parameter int unsigned IMG_WIDTH  = 16,
  parameter int unsigned MEM_AWIDTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [CFG_DWIDTH-1:0]         cfg_data_i,
  input  logic [CFG_AWIDTH-1:0]         cfg_addr_i,
  input  logic                          cfg_valid_i,
  input  logic                          next_i,
  input  logic [GROUP_NB*IMG_WIDTH-1:0] str_bus_i,
  input  logic                          str_last_i,
  input  logic                          str_val_i,
  output logic                          str_rdy_o,
  output logic                          wr_val_o,
  output logic [MEM_AWIDTH-1:0]         wr_addr_o,
  output logic [GROUP_NB*IMG_WIDTH-1:0] wr_data_o,
  output logic                          done_o,
  output logic                          err_o
);

  localparam int unsigned DW = GROUP_NB * IMG_WIDTH;

  state_e state_q, state_d;

  logic [DIM_W-1:0]      img_w_q, img_h_q, img_d_q;
  logic [DIM_W-1:0]      run_w_q, run_h_q, run_d_q;
  logic [MEM_AWIDTH-1:0] base_q, addr_q, wr_addr_q;
  logic [DW-1:0]         wr_data_q;
  logic                  wr_val_q, err_q;
  logic                  start, xfer, w_last, h_last, d_last, final_word;

  assign start      = state_q[RESET] && next_i;
  assign xfer       = state_q[ACTIVE] && str_val_i;
  assign final_word = w_last && h_last && d_last;

  assign str_rdy_o = state_q[ACTIVE];
  assign done_o    = state_q[DONE];
  assign wr_val_o  = wr_val_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign err_o     = err_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReset:  if (next_i) state_d = StActive;
      StActive: if (xfer && final_word) state_d = StDone;
      StDone:   state_d = StReset;
      default:  state_d = StReset;
    endcase
  end

  // Pass limits are snapshotted on start so a config write landing with next does not
  // affect the pass it launches.
  image_write_count u_count (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (start),
    .en_i     (xfer),
    .img_w_i  (run_w_q),
    .img_h_i  (run_h_q),
    .img_d_i  (run_d_q),
    .w_last_o (w_last),
    .h_last_o (h_last),
    .d_last_o (d_last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StReset;
      img_w_q   <= '0;
      img_h_q   <= '0;
      img_d_q   <= '0;
      base_q    <= '0;
      run_w_q   <= '0;
      run_h_q   <= '0;
      run_d_q   <= '0;
      addr_q    <= '0;
      err_q     <= 1'b0;
      wr_val_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q[RESET] && cfg_valid_i) begin
        case (cfg_addr_i)
          CFG_AWIDTH'(CFG_IW_IMG_W): img_w_q <= cfg_data_i[15:0];
          CFG_AWIDTH'(CFG_IW_IMG_DH): begin
            img_d_q <= cfg_data_i[31:16];
            img_h_q <= cfg_data_i[15:0];
          end
          CFG_AWIDTH'(CFG_IW_START): base_q <= cfg_data_i[MEM_AWIDTH-1:0];
          default: ;
        endcase
      end
      if (start) begin
        run_w_q <= img_w_q;
        run_h_q <= img_h_q;
        run_d_q <= img_d_q;
        addr_q  <= base_q;
        err_q   <= 1'b0;
      end else if (xfer) begin
        addr_q <= addr_q + MEM_AWIDTH'(1);
        if (str_last_i != final_word) err_q <= 1'b1;
      end
      wr_val_q <= xfer;
      if (xfer) begin
        wr_addr_q <= addr_q;
        wr_data_q <= str_bus_i;
      end
    end
  end

endmodule

// File: tb/tb_image_write.sv
// Self-checking bench for image_write: driver pushes expected writes, monitor pops and compares.
module tb_image_write;
  import image_write_pkg::*;

  typedef struct packed {
    logic [15:0] addr;
    logic [63:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg_data;
  logic [4:0]  cfg_addr;
  logic        cfg_valid, next;
  logic [63:0] str_bus;
  logic        str_last, str_val;
  logic        str_rdy, wr_val, done, err;
  logic [15:0] wr_addr;
  logic [63:0] wr_data;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  image_write dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cfg_data_i  (cfg_data),
    .cfg_addr_i  (cfg_addr),
    .cfg_valid_i (cfg_valid),
    .next_i      (next),
    .str_bus_i   (str_bus),
    .str_last_i  (str_last),
    .str_val_i   (str_val),
    .str_rdy_o   (str_rdy),
    .wr_val_o    (wr_val),
    .wr_addr_o   (wr_addr),
    .wr_data_o   (wr_data),
    .done_o      (done),
    .err_o       (err)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every write must match the oldest outstanding accepted word.
  always @(negedge clk) begin
    if (wr_val === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_wr", 64'(wr_addr), 64'hdead);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_val("wr_addr", 64'(wr_addr), 64'(e.addr));
        check_val("wr_data", wr_data, e.data);
      end
    end
  end

  task automatic cfg_write(input int unsigned addr, input logic [31:0] data);
    cfg_valid = 1'b1;
    cfg_addr  = 5'(addr);
    cfg_data  = data;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic run_pass(input int n, input logic [15:0] base, input int last_at,
                          input bit gaps, input int poke_at, input int rst_at);
    int   sent = 0;
    int   cyc  = 0;
    bit   err_seen = 1'b0;
    exp_t e;
    next = 1'b1;
    @(posedge clk); #1;
    next = 1'b0;
    check_val("err_clr_on_next", 64'(err), 64'(0));
    while (sent < n) begin
      if (cyc > 4 * n + 50) begin
        check_val("pass_timeout", 64'(sent), 64'(n));
        break;
      end
      if (rst_at > 0 && sent == rst_at) begin
        str_val = 1'b0;
        rst     = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("rst_wr_val", 64'(wr_val), 64'(0));
        check_val("rst_str_rdy", 64'(str_rdy), 64'(0));
        check_val("rst_done", 64'(done), 64'(0));
        @(negedge clk);
        check_val("rst_no_pending", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
        return;
      end
      str_val  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      str_bus  = {$urandom(), $urandom()};
      str_last = (sent + 1 == last_at);
      if (poke_at > 0 && sent == poke_at) begin
        next      = 1'b1;
        cfg_valid = 1'b1;
        cfg_addr  = 5'(CFG_IW_IMG_W);
        cfg_data  = 32'd3;
      end
      if (str_val && str_rdy) begin
        e.addr = base + 16'(sent);
        e.data = str_bus;
        exp_q.push_back(e);
        sent++;
      end
      @(posedge clk); #1;
      next      = 1'b0;
      cfg_valid = 1'b0;
      str_val   = 1'b0;
      str_last  = 1'b0;
      cyc++;
      if (last_at != n && sent == last_at && !err_seen) begin
        check_val("err_after_early_last", 64'(err), 64'(1));
        err_seen = 1'b1;
      end
    end
    check_val("done_with_last_wr", 64'(done), 64'(1));
    check_val("wr_val_with_done", 64'(wr_val), 64'(1));
    check_val("rdy_low_in_done", 64'(str_rdy), 64'(0));
    check_val("err_end", 64'(err), 64'(last_at != n));
    @(posedge clk); #1;
    check_val("done_one_cycle", 64'(done), 64'(0));
    check_val("queue_drained", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  initial begin
    rst       = 1'b1;
    cfg_data  = '0;
    cfg_addr  = '0;
    cfg_valid = 1'b0;
    next      = 1'b0;
    str_bus   = '0;
    str_last  = 1'b0;
    str_val   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("reset_str_rdy", 64'(str_rdy), 64'(0));
    check_val("reset_wr_val", 64'(wr_val), 64'(0));
    check_val("reset_wr_addr", 64'(wr_addr), 64'(0));
    check_val("reset_wr_data", wr_data, 64'(0));
    check_val("reset_done", 64'(done), 64'(0));
    check_val("reset_err", 64'(err), 64'(0));

    // 10x5x8 image at 0x0100
    cfg_write(CFG_IW_IMG_W, 32'd9);
    cfg_write(CFG_IW_IMG_DH, {16'd7, 16'd4});
    cfg_write(CFG_IW_START, 32'h0100);
    run_pass(400, 16'h0100, 400, 1'b0, 0, 0);
    run_pass(400, 16'h0100, 400, 1'b1, 0, 0);
    run_pass(400, 16'h0100, 5, 1'b0, 0, 0);
    run_pass(400, 16'h0100, 400, 1'b0, 50, 0);
    run_pass(400, 16'h0100, 400, 1'b1, 0, 0);

    // 1x1x4 across the top of the address space
    cfg_write(CFG_IW_IMG_W, 32'd0);
    cfg_write(CFG_IW_IMG_DH, {16'd3, 16'd0});
    cfg_write(CFG_IW_START, 32'hFFFE);
    run_pass(4, 16'hFFFE, 4, 1'b0, 0, 0);

    // Abort mid-pass, then config must be back to 1x1x1 at 0
    cfg_write(CFG_IW_IMG_W, 32'd9);
    cfg_write(CFG_IW_IMG_DH, {16'd7, 16'd4});
    cfg_write(CFG_IW_START, 32'h0100);
    run_pass(400, 16'h0100, 400, 1'b0, 0, 100);
    run_pass(1, 16'h0000, 1, 1'b0, 0, 0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
